readcommand_pkt: RTL and testbench
==================================

READCOMMAND_PKT -- requirements
Module: readcommand_pkt

Interface
REQ-001 SHALL have parameter DATA_W, default 8: FIFO word width in bits.
REQ-002 SHALL have parameter MAX_BYTES, default 4: maximum words per command, header included (range 2..16).
REQ-003 SHALL have parameter LATCH_TICK, default 5: ticks after rd assertion at which data is sampled.
REQ-004 SHALL have parameter END_TICK, default 6: tick at which rd deasserts; END_TICK > LATCH_TICK >= 1.
REQ-005 SHALL have parameter TIMEOUT, default 255: idle cycles allowed between words of one command.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port nef, input, 1: FIFO empty flag, active-low (1 = data present).
REQ-009 SHALL have port disp_cmd_rd, output, 1: FIFO read strobe, active-low.
REQ-010 SHALL have port disp_cmd_in, input, DATA_W: FIFO data.
REQ-011 SHALL have port cmdreg_data_avail, input, 1: shared register is occupied.
REQ-012 SHALL have port cmdreg_wr, output, 1: one-cycle write pulse to the shared register.
REQ-013 SHALL have port cmdreg_data_send, output, DATA_W*MAX_BYTES: assembled command; word i sits at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port cmdreg_len, output, LEN_W = clog2(MAX_BYTES+1): total words in the delivered command.
REQ-015 SHALL have port cmd_error, output, 1: one-cycle pulse on a length or timeout fault.

Function
REQ-016 SHALL implement the states IDLE, STROBE, RELEASE, NEXT and DELIVER.
REQ-017 SHALL, in IDLE, clear the word index and leave IDLE when nef=1, driving disp_cmd_rd=0 and tick=0 and entering STROBE. A command is never started while cmdreg_data_avail=1 only if a completed command is still pending; reading may start regardless.
REQ-018 SHALL, in STROBE, increment tick each cycle; at tick==LATCH_TICK it samples disp_cmd_in into word[index] and enters RELEASE.
REQ-019 SHALL, in RELEASE, increment tick; at tick==END_TICK it drives disp_cmd_rd=1 and increments index.
REQ-020 SHALL take header word 0: its bits [LEN_W-1:0] give the total length L. L=0 is treated as 1.
REQ-021 SHALL, when L>MAX_BYTES, pulse cmd_error, discard the header and return to IDLE without delivering anything.
REQ-022 SHALL, after RELEASE, enter DELIVER if index==L; otherwise it enters NEXT.
REQ-023 SHALL, in NEXT, count idle cycles while nef=0; nef=1 restarts STROBE with tick=0.
REQ-024 SHALL, when the NEXT count reaches TIMEOUT, pulse cmd_error, discard the partial command and return to IDLE.
REQ-025 SHALL, in DELIVER, wait while cmdreg_data_avail=1; once it is 0, it pulses cmdreg_wr for exactly 1 cycle, presents the data and length, and returns to IDLE.
REQ-026 SHALL hold cmdreg_data_send and cmdreg_len stable from the pulse until the next delivery.
REQ-027 SHALL zero the unused upper words of cmdreg_data_send.
REQ-028 SHALL use tick and timeout counters that saturate and never wrap.
REQ-029 SHALL give a minimum throughput of one word per END_TICK+2 cycles.

Reset
REQ-030 SHALL, on nrst=0 (asynchronous), force disp_cmd_rd=1, cmdreg_wr=0, cmd_error=0, cmdreg_data_send=0, cmdreg_len=0, state=IDLE and all counters to 0.
REQ-031 SHALL, on reset mid-read, abandon the partial command; the FIFO word under strobe is lost.
REQ-032 SHALL release reset with no output glitch; the first strobe comes no earlier than 1 cycle after deassertion.

Structure
REQ-033 SHALL place the state encoding and the RD_ASSERTED/FIFO_NOT_EMPTY constants in a shared package, cmd_pkg.
REQ-034 SHALL use one sub-module, rd_strobe_timer, which owns the tick counter and LATCH/END compares and is reusable by the write-side blocks.

Verification
REQ-035 SHALL cover a single-word command: header 0x01 present -> disp_cmd_rd low for ticks 0..6, cmdreg_wr pulse, data 0x00000001, len 1.
REQ-036 SHALL cover a 4-word command: words 0x04,0xAA,0xBB,0xCC -> data 0xCCBBAA04, len 4, a single cmdreg_wr pulse.
REQ-037 SHALL cover back-pressure: cmdreg_data_avail=1 at DELIVER for 20 cycles -> no cmdreg_wr until it drops, then exactly one pulse.
REQ-038 SHALL cover a timeout: header 0x03, then the FIFO stays empty for 256 cycles -> cmd_error pulse, no write, back in IDLE.
REQ-039 SHALL cover a bad length: header 0x07 with MAX_BYTES=4 -> cmd_error pulse, no write, next command decoded normally.
REQ-040 SHALL cover mid-strobe reset: nrst low during STROBE of word 2 -> disp_cmd_rd=1 immediately, all outputs at reset values.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared constants for the command-FIFO read/write blocks.
//   ST_*           : FSM state encodings (legacy 3-bit constants)
//   RD_ASSERTED    : active level of the FIFO read strobe
//   RD_RELEASED    : idle level of the FIFO read strobe
//   FIFO_NOT_EMPTY : level of the empty flag when data is present
package cmd_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_STROBE  = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_NEXT    = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;

    localparam logic RD_ASSERTED    = 1'b0;
    localparam logic RD_RELEASED    = 1'b1;
    localparam logic FIFO_NOT_EMPTY = 1'b1;

endpackage

// File: rtl/readcommand_pkt_if.sv
// Bundle of FIFO-side and command-register-side signals of readcommand_pkt.
//   nef               : FIFO empty flag, active-low (1 = data present)
//   disp_cmd_rd       : FIFO read strobe, active-low
//   disp_cmd_in       : FIFO data word
//   cmdreg_data_avail : shared command register still occupied
//   cmdreg_wr         : one-cycle write pulse into the command register
//   cmdreg_data_send  : assembled command, word i at [i*DATA_W +: DATA_W]
//   cmdreg_len        : number of words in the delivered command
//   cmd_error         : one-cycle pulse on a length or timeout fault
// slave  = the command reader, master = its environment.
interface readcommand_pkt_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 4
);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    logic                          nef;
    logic                          disp_cmd_rd;
    logic [DATA_W-1:0]             disp_cmd_in;
    logic                          cmdreg_data_avail;
    logic                          cmdreg_wr;
    logic [DATA_W*MAX_BYTES-1:0]   cmdreg_data_send;
    logic [LEN_W-1:0]              cmdreg_len;
    logic                          cmd_error;

    modport slave (
        input  nef, disp_cmd_in, cmdreg_data_avail,
        output disp_cmd_rd, cmdreg_wr, cmdreg_data_send, cmdreg_len, cmd_error
    );

    modport master (
        output nef, disp_cmd_in, cmdreg_data_avail,
        input  disp_cmd_rd, cmdreg_wr, cmdreg_data_send, cmdreg_len, cmd_error
    );

endinterface

// File: rtl/rd_strobe_timer.sv
// Tick counter for a FIFO read strobe cycle.
//   clk, nrst  : clock, asynchronous active-low reset
//   i_clr      : restart the count at 0 (priority over i_en)
//   i_en       : advance one tick; the count saturates at END_TICK
//   o_at_latch : tick == LATCH_TICK (sample the data word)
//   o_at_end   : tick == END_TICK (release the strobe)
module rd_strobe_timer #(
    parameter int LATCH_TICK = 5,
    parameter int END_TICK   = 6
)(
    input  logic clk,
    input  logic nrst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_at_latch,
    output logic o_at_end
);
    localparam int TICK_W = $clog2(END_TICK + 1);
    localparam logic [TICK_W-1:0] TICK_LATCH = TICK_W'(LATCH_TICK);
    localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(END_TICK);

    logic [TICK_W-1:0] r_tick;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tick <= '0;
        end else if (i_clr) begin
            r_tick <= '0;
        end else if (i_en && (r_tick != TICK_MAX)) begin
            r_tick <= r_tick + TICK_W'(1);
        end
    end

    assign o_at_latch = (r_tick == TICK_LATCH);
    assign o_at_end   = (r_tick == TICK_MAX);

endmodule

// File: rtl/readcommand_pkt.sv
// Reads a variable-length command from a FIFO (header word 0 carries the total
// length in its low LEN_W bits) and hands it to a shared command register.
//   clk, nrst : clock, asynchronous active-low reset
//   cmd_bus   : FIFO strobe/data and command-register handshake (slave side)
module readcommand_pkt
    import cmd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAX_BYTES  = 4,
    parameter int LATCH_TICK = 5,
    parameter int END_TICK   = 6,
    parameter int TIMEOUT    = 255
)(
    input  logic              clk,
    input  logic              nrst,
    readcommand_pkt_if.slave  cmd_bus
);
    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

    logic [2:0]                  r_state;
    logic                        r_rd;
    logic                        r_wr;
    logic                        r_err;
    logic [DATA_W*MAX_BYTES-1:0] r_data;
    logic [LEN_W-1:0]            r_len;
    logic [LEN_W-1:0]            r_idx;
    logic [TO_W-1:0]             r_to_cnt;
    logic [DATA_W-1:0]           r_words [MAX_BYTES];

    logic [LEN_W-1:0]            w_hdr;
    logic [LEN_W-1:0]            w_len;
    logic                        w_len_bad;
    logic [LEN_W-1:0]            w_idx_inc;
    logic [DATA_W*MAX_BYTES-1:0] w_assembled;
    logic                        w_data_present;
    logic                        w_tick_clr;
    logic                        w_tick_en;
    logic                        w_at_latch;
    logic                        w_at_end;

    // Length comes from word 0; a zero header still means a one-word command.
    assign w_hdr     = r_words[0][LEN_W-1:0];
    assign w_len     = (w_hdr == '0) ? LEN_W'(1) : w_hdr;
    assign w_len_bad = (w_len > LEN_MAX);
    assign w_idx_inc = r_idx + LEN_W'(1);

    assign w_data_present = (cmd_bus.nef == FIFO_NOT_EMPTY);
    assign w_tick_clr = ((r_state == ST_IDLE) || (r_state == ST_NEXT)) && w_data_present;
    assign w_tick_en  = (r_state == ST_STROBE) || (r_state == ST_RELEASE);

    // Words at or beyond the length may hold stale data from earlier commands.
    for (genvar g = 0; g < MAX_BYTES; g++) begin : g_asm
        assign w_assembled[g*DATA_W +: DATA_W] = (LEN_W'(g) < w_len) ? r_words[g] : '0;
    end

    rd_strobe_timer #(
        .LATCH_TICK (LATCH_TICK),
        .END_TICK   (END_TICK)
    ) u_timer (
        .clk        (clk),
        .nrst       (nrst),
        .i_clr      (w_tick_clr),
        .i_en       (w_tick_en),
        .o_at_latch (w_at_latch),
        .o_at_end   (w_at_end)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_IDLE;
            r_rd     <= RD_RELEASED;
            r_wr     <= 1'b0;
            r_err    <= 1'b0;
            r_data   <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_to_cnt <= '0;
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                r_words[i] <= '0;
            end
        end else begin
            r_wr  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    if (w_data_present) begin
                        r_rd    <= RD_ASSERTED;
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (w_at_latch) begin
                        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                            if (r_idx == LEN_W'(i)) begin
                                r_words[i] <= cmd_bus.disp_cmd_in;
                            end
                        end
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (w_at_end) begin
                        r_rd     <= RD_RELEASED;
                        r_idx    <= w_idx_inc;
                        r_to_cnt <= '0;
                        // Word 0 never changes within a command, so the length
                        // check is only ever taken on the header's release.
                        if (w_len_bad) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_idx_inc == w_len) begin
                            r_state <= ST_DELIVER;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end
                end
                ST_NEXT: begin
                    if (w_data_present) begin
                        r_rd    <= RD_ASSERTED;
                        r_state <= ST_STROBE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_DELIVER: begin
                    if (!cmd_bus.cmdreg_data_avail) begin
                        r_wr    <= 1'b1;
                        r_data  <= w_assembled;
                        r_len   <= w_len;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_bus.disp_cmd_rd      = r_rd;
    assign cmd_bus.cmdreg_wr        = r_wr;
    assign cmd_bus.cmd_error        = r_err;
    assign cmd_bus.cmdreg_data_send = r_data;
    assign cmd_bus.cmdreg_len       = r_len;

endmodule

// File: tb/tb_readcommand_pkt.sv
// Directed bench for readcommand_pkt: a queue models the FIFO (word popped when
// the read strobe is released), a negedge monitor counts pulses and strobe
// cycles, and a table of commands plus hand sequences compare the results.
module tb_readcommand_pkt;

    typedef struct packed {
        logic [2:0]  n;         // words pushed into the FIFO
        logic [31:0] words;     // word j at [8*j +: 8]
        logic [31:0] exp_data;
        logic [2:0]  exp_len;
        logic        exp_err;
    } vec_t;

    logic clk;
    logic nrst;

    readcommand_pkt_if #(.DATA_W(8), .MAX_BYTES(4)) cmd_bus ();

    readcommand_pkt #(
        .DATA_W     (8),
        .MAX_BYTES  (4),
        .LATCH_TICK (5),
        .END_TICK   (6),
        .TIMEOUT    (255)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .cmd_bus (cmd_bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0]  q[$];
    int unsigned wr_count    = 0;
    int unsigned err_count   = 0;
    int unsigned rd_low_cnt  = 0;
    int unsigned rd_fall_cnt = 0;
    int unsigned last_wait   = 0;
    logic [31:0] hold_data   = '0;
    logic [2:0]  hold_len    = '0;

    vec_t vecs [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model and output monitor, both evaluated on the falling edge.
    initial begin
        logic rd_prev;
        rd_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_bus.cmdreg_wr === 1'b1) wr_count++;
            if (cmd_bus.cmd_error === 1'b1) err_count++;
            if (cmd_bus.disp_cmd_rd === 1'b0) rd_low_cnt++;
            if (rd_prev === 1'b1 && cmd_bus.disp_cmd_rd === 1'b0) rd_fall_cnt++;
            if (rd_prev === 1'b0 && cmd_bus.disp_cmd_rd === 1'b1 && q.size() > 0) void'(q.pop_front());
            rd_prev = cmd_bus.disp_cmd_rd;
            cmd_bus.nef         = (q.size() > 0);
            cmd_bus.disp_cmd_in = (q.size() > 0) ? q[0] : 8'h00;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_evt(input int unsigned w0, input int unsigned e0,
                            input int unsigned limit, output bit ok);
        int unsigned waited;
        ok = 1'b0;
        waited = 0;
        while (waited < limit && !ok) begin
            @(posedge clk);
            waited++;
            if (wr_count != w0 || err_count != e0) ok = 1'b1;
        end
        last_wait = waited;
    endtask

    function automatic vec_t mk(input logic [2:0] n, input logic [31:0] w,
                                input logic [31:0] d, input logic [2:0] l, input logic e);
        vec_t v;
        v.n = n; v.words = w; v.exp_data = d; v.exp_len = l; v.exp_err = e;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned w0, e0, r0;
        bit ok;
        logic [31:0] wv;
        w0 = wr_count; e0 = err_count; r0 = rd_low_cnt;
        wv = v.words;
        for (int unsigned j = 0; j < 32'(v.n); j++) q.push_back(8'(wv >> (8 * j)));
        wait_evt(w0, e0, 200, ok);
        chk({tag, "_done"}, 64'(ok), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_wr"},    64'(wr_count - w0),   v.exp_err ? 64'd0 : 64'd1);
        chk({tag, "_err"},   64'(err_count - e0),  64'(v.exp_err));
        chk({tag, "_rdlow"}, 64'(rd_low_cnt - r0), 64'(v.n) * 64'd7);
        if (!v.exp_err) begin
            hold_data = v.exp_data;
            hold_len  = v.exp_len;
        end
        chk({tag, "_data"}, 64'(cmd_bus.cmdreg_data_send), 64'(hold_data));
        chk({tag, "_len"},  64'(cmd_bus.cmdreg_len),       64'(hold_len));
        chk({tag, "_fifo"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int unsigned w0, e0, f0, waited;
        bit ok;

        vecs[0] = mk(3'd1, 32'h0000_0001, 32'h0000_0001, 3'd1, 1'b0);
        vecs[1] = mk(3'd4, 32'hCCBB_AA04, 32'hCCBB_AA04, 3'd4, 1'b0);
        vecs[2] = mk(3'd2, 32'h0000_5A02, 32'h0000_5A02, 3'd2, 1'b0);
        vecs[3] = mk(3'd1, 32'h0000_0000, 32'h0000_0000, 3'd1, 1'b0);  // L=0 -> 1
        vecs[4] = mk(3'd1, 32'h0000_0007, 32'h0000_0000, 3'd0, 1'b1);  // L=7 > 4
        vecs[5] = mk(3'd3, 32'h0022_11F3, 32'h0022_11F3, 3'd3, 1'b0);  // upper header bits ignored
        vecs[6] = mk(3'd1, 32'h0000_0005, 32'h0000_0000, 3'd0, 1'b1);  // L=5 > 4
        vecs[7] = mk(3'd4, 32'h0302_010C, 32'h0302_010C, 3'd4, 1'b0);

        nrst = 1'b0;
        cmd_bus.cmdreg_data_avail = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd",   64'(cmd_bus.disp_cmd_rd),      64'd1);
        chk("rst_wr",   64'(cmd_bus.cmdreg_wr),        64'd0);
        chk("rst_err",  64'(cmd_bus.cmd_error),        64'd0);
        chk("rst_data", 64'(cmd_bus.cmdreg_data_send), 64'd0);
        chk("rst_len",  64'(cmd_bus.cmdreg_len),       64'd0);
        #2 nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_rd", 64'(cmd_bus.disp_cmd_rd), 64'd1);

        for (int unsigned k = 0; k < 8; k++) begin
            run_vec(vecs[k], $sformatf("v%0d", k));
        end

        // Back-pressure: register stays occupied well past the read.
        cmd_bus.cmdreg_data_avail = 1'b1;
        w0 = wr_count;
        e0 = err_count;
        q.push_back(8'h02);
        q.push_back(8'h77);
        repeat (45) @(posedge clk);
        #1;
        chk("bp_hold_wr", 64'(wr_count - w0), 64'd0);
        chk("bp_fifo",    64'(q.size()),      64'd0);
        chk("bp_data_old", 64'(cmd_bus.cmdreg_data_send), 64'(hold_data));
        cmd_bus.cmdreg_data_avail = 1'b0;
        wait_evt(w0, e0, 10, ok);
        chk("bp_done", 64'(ok), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_wr",   64'(wr_count - w0),             64'd1);
        chk("bp_data", 64'(cmd_bus.cmdreg_data_send),  64'h0000_7702);
        chk("bp_len",  64'(cmd_bus.cmdreg_len),        64'd2);
        hold_data = 32'h0000_7702;
        hold_len  = 3'd2;

        // Timeout: header promises 3 words, FIFO then stays empty.
        w0 = wr_count;
        e0 = err_count;
        q.push_back(8'h03);
        wait_evt(w0, e0, 400, ok);
        waited = last_wait;
        chk("to_done", 64'(ok), 64'd1);
        chk("to_window", 64'(waited >= 255 && waited <= 280), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("to_err",  64'(err_count - e0), 64'd1);
        chk("to_wr",   64'(wr_count - w0),  64'd0);
        chk("to_data", 64'(cmd_bus.cmdreg_data_send), 64'(hold_data));
        chk("to_len",  64'(cmd_bus.cmdreg_len),       64'(hold_len));
        run_vec(mk(3'd2, 32'h0000_9902, 32'h0000_9902, 3'd2, 1'b0), "to_after");

        // Reset while word 2 of a 4-word command is under strobe.
        f0 = rd_fall_cnt;
        q.push_back(8'h04);
        q.push_back(8'hAA);
        q.push_back(8'hBB);
        q.push_back(8'hCC);
        ok = 1'b0;
        for (int unsigned c = 0; c < 100 && !ok; c++) begin
            @(posedge clk);
            if (rd_fall_cnt - f0 == 3) ok = 1'b1;
        end
        chk("mr_reach", 64'(ok), 64'd1);
        @(posedge clk);
        #2;
        chk("mr_rd_before", 64'(cmd_bus.disp_cmd_rd), 64'd0);
        nrst = 1'b0;
        #1;
        chk("mr_rd",   64'(cmd_bus.disp_cmd_rd),      64'd1);
        chk("mr_wr",   64'(cmd_bus.cmdreg_wr),        64'd0);
        chk("mr_err",  64'(cmd_bus.cmd_error),        64'd0);
        chk("mr_data", 64'(cmd_bus.cmdreg_data_send), 64'd0);
        chk("mr_len",  64'(cmd_bus.cmdreg_len),       64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        q.delete();
        #2 nrst = 1'b1;
        hold_data = '0;
        hold_len  = '0;
        run_vec(mk(3'd2, 32'h0000_3302, 32'h0000_3302, 3'd2, 1'b0), "mr_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
